// File: rtl/stream_nor_deser_pkg.sv
// Shared state encoding and helpers for the bit-serial NOR receiver.
`ifndef STREAM_NOR_DESER_DEFS
`define STREAM_NOR_DESER_DEFS
`define SND_COLLECT 1'b0
`define SND_DONE    1'b1
`endif

package stream_nor_deser_pkg;

    typedef enum logic {
        ST_COLLECT = `SND_COLLECT,
        ST_DONE    = `SND_DONE
    } state_t;

    // A counter of at least one bit, even for single-bit words.
    function automatic int cnt_width(input int way);
        return $clog2(way > 1 ? way : 2);
    endfunction

endpackage

// File: rtl/stream_nor_deser_nor.sv
// NOR reduction of a WAY-bit word, as an explicit OR chain or as a reduction operator.
module serial_nor #(
    parameter int WAY        = 3,
    parameter bit BEHAVIORAL = 0
) (
    input  logic [WAY-1:0] a,
    output logic           y
);

    if (BEHAVIORAL) begin : g_beh
        assign y = ~|a;
    end else begin : g_gate
        for (genvar i = 0; i < WAY; i++) begin : g_or
            logic acc;
            if (i == 0) begin : g_first
                assign acc = a[0];
            end else begin : g_next
                assign acc = g_or[i-1].acc | a[i];
            end
        end
        assign y = ~g_or[WAY-1].acc;
    end

endmodule

// File: rtl/stream_nor_deser.sv
// Bit-serial receiver: rebuilds a WAY-bit word LSB first and presents it with its NOR.
module stream_nor_deser
    import stream_nor_deser_pkg::*;
#(
    parameter int WAY        = 3,
    parameter bit BEHAVIORAL = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_bit,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out,
    output logic [WAY-1:0] out_word
);

    localparam int            CW   = cnt_width(WAY);
    localparam logic [CW-1:0] LAST = CW'(WAY - 1);

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [WAY-1:0]  word, word_n;
    logic            accept, load, nor_w;

    assign in_ready  = (state == ST_COLLECT) | out_ready;
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid & in_ready & ~clear;
    assign out_word  = word;

    always_comb begin
        word_n = word;
        if (accept)
            word_n[cnt] = in_bit;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        case (state)
            ST_COLLECT: begin
                if (accept) begin
                    if (cnt == LAST) begin
                        state_n = ST_DONE;
                        cnt_n   = '0;
                        load    = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (!accept) begin
                        state_n = ST_COLLECT;
                        cnt_n   = '0;
                    end else if (WAY == 1) begin
                        // Single-bit words complete on every accepted bit.
                        state_n = ST_DONE;
                        cnt_n   = '0;
                        load    = 1'b1;
                    end else begin
                        state_n = ST_COLLECT;
                        cnt_n   = CW'(1);
                    end
                end
            end
            default: begin
                state_n = ST_COLLECT;
                cnt_n   = '0;
            end
        endcase
        if (clear) begin
            state_n = ST_COLLECT;
            cnt_n   = '0;
            load    = 1'b0;
        end
    end

    // Reduction sees the word including the bit landing this cycle.
    serial_nor #(
        .WAY        (WAY),
        .BEHAVIORAL (BEHAVIORAL)
    ) u_nor (
        .a (word_n),
        .y (nor_w)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_COLLECT;
            cnt   <= '0;
            word  <= '0;
            out   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            word  <= word_n;
            if (load)
                out <= nor_w;
        end
    end

endmodule
